// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: registered Wishbone classic single-transfer master with timeout
module wb_master_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_dir,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic [SEL_W-1:0]  cpu_sel,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_tmo,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              we_o,
    output logic              stb_o,
    output logic              cyc_o
);
    typedef enum logic {IDLE, BUS} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             term, tmo;

    assign tmo  = !ack_i && !err_i && (cnt_q == CNT_W'(TIMEOUT));
    assign term = ack_i || err_i || tmo;

    // Transfer FSM: latch request in IDLE, hold the bus cycle until ACK/ERR/timeout
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            sel_o      <= '0;
            cpu_data_o <= '0;
            cpu_busy   <= 1'b0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_tmo    <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            cpu_tmo  <= 1'b0;
            if (state_q == IDLE) begin
                if (cpu_rd ^ cpu_wr) begin
                    state_q  <= BUS;
                    cnt_q    <= '0;
                    adr_o    <= cpu_dir;
                    dat_o    <= cpu_data_i;
                    sel_o    <= cpu_sel;
                    we_o     <= cpu_wr;
                    cyc_o    <= 1'b1;
                    stb_o    <= 1'b1;
                    cpu_busy <= 1'b1;
                end else if (cpu_rd && cpu_wr) begin
                    cpu_done <= 1'b1;
                    cpu_err  <= 1'b1;
                end
            end else if (term) begin
                state_q  <= IDLE;
                cyc_o    <= 1'b0;
                stb_o    <= 1'b0;
                cpu_busy <= 1'b0;
                cpu_done <= 1'b1;
                cpu_err  <= err_i || tmo;
                cpu_tmo  <= tmo;
                if (ack_i && !err_i && !we_o) cpu_data_o <= dat_i;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl: directed tests for the Wishbone master, 8-bit and 32-bit builds
module tb_wb_master_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic        cpu_rd = 0, cpu_wr = 0;
    logic [15:0] cpu_dir = '0;
    logic [7:0]  cpu_data_i = '0;
    logic [0:0]  cpu_sel = '0;
    logic [7:0]  cpu_data_o;
    logic        cpu_busy, cpu_done, cpu_err, cpu_tmo;
    logic        ack = 0, err = 0;
    logic [7:0]  dat_i = '0;
    logic [7:0]  dat_o;
    logic [15:0] adr_o;
    logic [0:0]  sel_o;
    logic        we_o, stb_o, cyc_o;

    logic        w_rd = 0, w_wr = 0;
    logic [31:0] w_dir = '0;
    logic [31:0] w_data_i = '0;
    logic [3:0]  w_sel = '0;
    logic [31:0] w_data_o;
    logic        w_busy, w_done, w_err, w_tmo;
    logic        w_ack = 0, w_errin = 0;
    logic [31:0] w_dat_i = '0;
    logic [31:0] w_dat_o;
    logic [31:0] w_adr_o;
    logic [3:0]  w_sel_o;
    logic        w_we_o, w_stb_o, w_cyc_o;

    always #5 clk = ~clk;

    wb_master_ctrl u_dut (
        .clk_i(clk), .rst_i(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dir(cpu_dir),
        .cpu_data_i(cpu_data_i), .cpu_sel(cpu_sel), .cpu_data_o(cpu_data_o), .cpu_busy(cpu_busy),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_tmo(cpu_tmo), .ack_i(ack), .err_i(err),
        .dat_i(dat_i), .dat_o(dat_o), .adr_o(adr_o), .sel_o(sel_o), .we_o(we_o),
        .stb_o(stb_o), .cyc_o(cyc_o)
    );

    wb_master_ctrl #(.DATA_W(32), .ADDR_W(32)) u_wide (
        .clk_i(clk), .rst_i(rst), .cpu_rd(w_rd), .cpu_wr(w_wr), .cpu_dir(w_dir),
        .cpu_data_i(w_data_i), .cpu_sel(w_sel), .cpu_data_o(w_data_o), .cpu_busy(w_busy),
        .cpu_done(w_done), .cpu_err(w_err), .cpu_tmo(w_tmo), .ack_i(w_ack), .err_i(w_errin),
        .dat_i(w_dat_i), .dat_o(w_dat_o), .adr_o(w_adr_o), .sel_o(w_sel_o), .we_o(w_we_o),
        .stb_o(w_stb_o), .cyc_o(w_cyc_o)
    );

    // flags packed as {cyc, stb, busy, we} and {done, err, tmo}
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cyc_o, stb_o, cpu_busy, we_o, cpu_done, cpu_err, cpu_tmo} !== 7'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000000", {cyc_o, stb_o, cpu_busy, we_o, cpu_done, cpu_err, cpu_tmo});
        end
        checks++;
        if ({adr_o, dat_o, sel_o, cpu_data_o} !== 33'b0) begin
            errors++; $display("FAIL reset_regs got %h exp 0", {adr_o, dat_o, sel_o, cpu_data_o});
        end
        checks++;
        if ({w_cyc_o, w_busy, w_done, w_adr_o, w_data_o} !== 67'b0) begin
            errors++; $display("FAIL reset_wide got %h exp 0", {w_cyc_o, w_busy, w_done, w_adr_o, w_data_o});
        end
        rst = 1'b0;
        ack = 1'b1; err = 1'b1;
        tick();
        ack = 1'b0; err = 1'b0;
        checks++;
        if ({cyc_o, cpu_busy, cpu_done, cpu_err} !== 4'b0) begin
            errors++; $display("FAIL idle_ack_ignored got %b exp 0000", {cyc_o, cpu_busy, cpu_done, cpu_err});
        end
    endtask

    task automatic test_write();
        cpu_wr = 1; cpu_dir = 16'h1234; cpu_data_i = 8'hA5; cpu_sel = 1'b1;
        tick();
        cpu_wr = 0;
        checks++;
        if ({cyc_o, stb_o, cpu_busy, we_o} !== 4'b1111 || adr_o !== 16'h1234 || dat_o !== 8'hA5 || sel_o !== 1'b1) begin
            errors++; $display("FAIL write_bus got flags %b adr %h dat %h sel %b exp 1111 1234 a5 1", {cyc_o, stb_o, cpu_busy, we_o}, adr_o, dat_o, sel_o);
        end
        ack = 1;
        tick();
        ack = 0;
        checks++;
        if ({cyc_o, stb_o, cpu_busy, cpu_done, cpu_err, cpu_tmo} !== 6'b000100) begin
            errors++; $display("FAIL write_done got %b exp 000100", {cyc_o, stb_o, cpu_busy, cpu_done, cpu_err, cpu_tmo});
        end
        tick();
        checks++;
        if (cpu_done !== 1'b0) begin
            errors++; $display("FAIL write_done_pulse got %b exp 0", cpu_done);
        end
    endtask

    task automatic test_read_wait();
        cpu_rd = 1; cpu_dir = 16'h00FF; cpu_sel = 1'b1;
        tick();
        cpu_rd = 0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({cyc_o, stb_o, we_o, cpu_done} !== 4'b1100 || adr_o !== 16'h00FF) begin
                errors++; $display("FAIL read_wait%0d got %b adr %h exp 1100 00ff", i, {cyc_o, stb_o, we_o, cpu_done}, adr_o);
            end
            tick();
        end
        checks++;
        if (cyc_o !== 1'b1) begin
            errors++; $display("FAIL read_cycle4 got cyc %b exp 1", cyc_o);
        end
        ack = 1; dat_i = 8'h3C;
        tick();
        ack = 0; dat_i = 8'h00;
        checks++;
        if ({cyc_o, cpu_done, cpu_err, cpu_tmo} !== 4'b0100 || cpu_data_o !== 8'h3C) begin
            errors++; $display("FAIL read_done got %b data %h exp 0100 3c", {cyc_o, cpu_done, cpu_err, cpu_tmo}, cpu_data_o);
        end
        tick();
        checks++;
        if (cpu_done !== 1'b0 || cpu_data_o !== 8'h3C) begin
            errors++; $display("FAIL read_after got done %b data %h exp 0 3c", cpu_done, cpu_data_o);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        cpu_rd = 1; cpu_dir = 16'h0010;
        tick();
        cpu_rd = 0;
        while (cyc_o === 1'b1 && n < 40) begin
            n++;
            if (cpu_done !== 1'b0) begin
                checks++; errors++; $display("FAIL tmo_early_done at cycle %0d got 1 exp 0", n);
            end
            tick();
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL tmo_cycles got %0d exp 16", n);
        end
        checks++;
        if ({cyc_o, cpu_busy, cpu_done, cpu_err, cpu_tmo} !== 5'b00111 || cpu_data_o !== 8'h3C) begin
            errors++; $display("FAIL tmo_done got %b data %h exp 00111 3c", {cyc_o, cpu_busy, cpu_done, cpu_err, cpu_tmo}, cpu_data_o);
        end
        tick();
        checks++;
        if ({cpu_done, cpu_err, cpu_tmo} !== 3'b000) begin
            errors++; $display("FAIL tmo_pulse got %b exp 000", {cpu_done, cpu_err, cpu_tmo});
        end
    endtask

    task automatic test_err_ack();
        cpu_rd = 1; cpu_dir = 16'h0020;
        tick();
        cpu_rd = 0;
        ack = 1; err = 1; dat_i = 8'h77;
        tick();
        ack = 0; err = 0; dat_i = 8'h00;
        checks++;
        if ({cyc_o, cpu_done, cpu_err, cpu_tmo} !== 4'b0110 || cpu_data_o !== 8'h3C) begin
            errors++; $display("FAIL err_ack got %b data %h exp 0110 3c", {cyc_o, cpu_done, cpu_err, cpu_tmo}, cpu_data_o);
        end
        tick();
    endtask

    task automatic test_illegal_busy();
        cpu_rd = 1; cpu_wr = 1;
        tick();
        cpu_rd = 0; cpu_wr = 0;
        checks++;
        if ({cyc_o, stb_o, cpu_busy, cpu_done, cpu_err, cpu_tmo} !== 6'b000110) begin
            errors++; $display("FAIL illegal got %b exp 000110", {cyc_o, stb_o, cpu_busy, cpu_done, cpu_err, cpu_tmo});
        end
        tick();
        checks++;
        if ({cyc_o, cpu_done, cpu_err} !== 3'b000) begin
            errors++; $display("FAIL illegal_after got %b exp 000", {cyc_o, cpu_done, cpu_err});
        end
        cpu_rd = 1; cpu_dir = 16'h0042;
        tick();
        cpu_rd = 0;
        tick();
        cpu_wr = 1; cpu_dir = 16'h9999; cpu_data_i = 8'hEE;
        tick();
        cpu_wr = 0;
        checks++;
        if ({cyc_o, we_o} !== 2'b10 || adr_o !== 16'h0042) begin
            errors++; $display("FAIL busy_ignore got cyc/we %b adr %h exp 10 0042", {cyc_o, we_o}, adr_o);
        end
        ack = 1; dat_i = 8'h5A;
        tick();
        ack = 0; dat_i = 8'h00;
        checks++;
        if ({cyc_o, cpu_done, cpu_err} !== 3'b010 || cpu_data_o !== 8'h5A) begin
            errors++; $display("FAIL busy_done got %b data %h exp 010 5a", {cyc_o, cpu_done, cpu_err}, cpu_data_o);
        end
        tick();
        checks++;
        if ({cyc_o, cpu_busy, cpu_done} !== 3'b000) begin
            errors++; $display("FAIL single_transfer got %b exp 000", {cyc_o, cpu_busy, cpu_done});
        end
    endtask

    task automatic test_reset_mid();
        cpu_wr = 1; cpu_dir = 16'h0ABC; cpu_data_i = 8'h99;
        tick();
        cpu_wr = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({cyc_o, stb_o, cpu_busy, cpu_done, cpu_err} !== 5'b0 || adr_o !== 16'h0) begin
            errors++; $display("FAIL reset_mid got %b adr %h exp 00000 0000", {cyc_o, stb_o, cpu_busy, cpu_done, cpu_err}, adr_o);
        end
        cpu_wr = 1; cpu_dir = 16'h5555; cpu_data_i = 8'h11;
        tick();
        cpu_wr = 0;
        checks++;
        if ({cyc_o, we_o} !== 2'b11 || adr_o !== 16'h5555 || dat_o !== 8'h11) begin
            errors++; $display("FAIL post_reset_bus got %b adr %h dat %h exp 11 5555 11", {cyc_o, we_o}, adr_o, dat_o);
        end
        ack = 1;
        tick();
        ack = 0;
        checks++;
        if ({cyc_o, cpu_done, cpu_err} !== 3'b010) begin
            errors++; $display("FAIL post_reset_done got %b exp 010", {cyc_o, cpu_done, cpu_err});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_wr = 1; cpu_dir = 16'h0100; cpu_data_i = 8'h01;
        tick();
        cpu_wr = 0; ack = 1;
        tick();
        ack = 0;
        cpu_rd = 1; cpu_dir = 16'h0077;
        checks++;
        if ({cyc_o, cpu_done} !== 2'b01) begin
            errors++; $display("FAIL b2b_first_done got %b exp 01", {cyc_o, cpu_done});
        end
        tick();
        cpu_rd = 0;
        checks++;
        if ({cyc_o, we_o, cpu_done} !== 3'b100 || adr_o !== 16'h0077) begin
            errors++; $display("FAIL b2b_accept got %b adr %h exp 100 0077", {cyc_o, we_o, cpu_done}, adr_o);
        end
        ack = 1; dat_i = 8'hC3;
        tick();
        ack = 0; dat_i = 8'h00;
        checks++;
        if ({cyc_o, cpu_done, cpu_err} !== 3'b010 || cpu_data_o !== 8'hC3) begin
            errors++; $display("FAIL b2b_second got %b data %h exp 010 c3", {cyc_o, cpu_done, cpu_err}, cpu_data_o);
        end
        tick();
    endtask

    task automatic test_wide();
        w_wr = 1; w_dir = 32'h0000_1234; w_data_i = 32'hDEAD_BEEF; w_sel = 4'b0110;
        tick();
        w_wr = 0;
        checks++;
        if ({w_cyc_o, w_stb_o, w_we_o} !== 3'b111 || w_adr_o !== 32'h0000_1234 || w_dat_o !== 32'hDEAD_BEEF || w_sel_o !== 4'b0110) begin
            errors++; $display("FAIL wide_write_bus got %b adr %h dat %h sel %b exp 111 00001234 deadbeef 0110", {w_cyc_o, w_stb_o, w_we_o}, w_adr_o, w_dat_o, w_sel_o);
        end
        w_ack = 1;
        tick();
        w_ack = 0;
        checks++;
        if ({w_cyc_o, w_done, w_err, w_tmo} !== 4'b0100) begin
            errors++; $display("FAIL wide_write_done got %b exp 0100", {w_cyc_o, w_done, w_err, w_tmo});
        end
        tick();
        w_rd = 1; w_dir = 32'h0000_00FF;
        tick();
        w_rd = 0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({w_cyc_o, w_we_o, w_done} !== 3'b100) begin
                errors++; $display("FAIL wide_read_wait%0d got %b exp 100", i, {w_cyc_o, w_we_o, w_done});
            end
            tick();
        end
        w_ack = 1; w_dat_i = 32'hCAFE_F00D;
        tick();
        w_ack = 0; w_dat_i = '0;
        checks++;
        if ({w_cyc_o, w_done, w_err} !== 3'b010 || w_data_o !== 32'hCAFE_F00D || w_sel_o !== 4'b0110) begin
            errors++; $display("FAIL wide_read_done got %b data %h sel %b exp 010 cafef00d 0110", {w_cyc_o, w_done, w_err}, w_data_o, w_sel_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_err_ack();
        test_illegal_busy();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
